// File: rtl/bram_pkg.sv
// Shared constants and helpers for the byte-write single-port block RAM.
// No ports: read-mode codes, FSM state type, lane-count and parameter checks.
package bram_pkg;

    localparam int RD_FIRST  = 0;
    localparam int WR_FIRST  = 1;
    localparam int NO_CHANGE = 2;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } bram_state_t;

    function automatic int calc_nb(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

    function automatic bit params_ok(input int data_w, input int byte_w,
                                     input int addr_w, input int depth);
        return ((data_w % byte_w) == 0) &&
               (longint'(depth) <= (longint'(1) << addr_w));
    endfunction

endpackage

// File: rtl/bram_core.sv
// Block-RAM array with byte-lane writes and a mode-dependent read register.
// Ports: i_clk, i_rst (read reg only), i_be/i_addr/i_din write side, i_we, i_rd, i_oor, o_rdata.
module bram_core
    import bram_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int BYTE_W    = 8,
    parameter int ADDR_W    = 11,
    parameter int DEPTH     = 2048,
    parameter int READ_MODE = RD_FIRST
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [calc_nb(DATA_W,BYTE_W)-1:0] i_be,
    input  logic                              i_we,
    input  logic                              i_rd,
    input  logic                              i_oor,
    input  logic [ADDR_W-1:0]                 i_addr,
    input  logic [DATA_W-1:0]                 i_din,
    output logic [DATA_W-1:0]                 o_rdata
);

    localparam int NB = calc_nb(DATA_W, BYTE_W);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_merged;

    assign w_old = r_mem[i_addr];

    // Word as it will look after this cycle's lane writes (write-first view).
    always_comb begin
        w_merged = w_old;
        for (int i = 0; i < NB; i++) begin
            if (i_be[i]) begin
                w_merged[i*BYTE_W +: BYTE_W] = i_din[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NB; i++) begin
            if (i_be[i]) begin
                r_mem[i_addr][i*BYTE_W +: BYTE_W] <= i_din[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_rd) begin
            if (i_oor) begin
                r_rdata <= '0;
            end else if (READ_MODE == WR_FIRST && i_we) begin
                r_rdata <= w_merged;
            end else begin
                r_rdata <= w_old;
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sp_bram_bytewr.sv
// Parametrised single-port block RAM: byte enables, read modes, output reg, clear sweep.
// Ports: i_clk, i_rst, i_en, i_we, i_be, i_addr, i_din, o_dout, o_dout_valid, o_busy.
module sp_bram_bytewr
    import bram_pkg::*;
#(
    parameter int              DATA_W       = 16,
    parameter int              BYTE_W       = 8,
    parameter int              ADDR_W       = 11,
    parameter int              DEPTH        = 2048,
    parameter int              READ_MODE    = RD_FIRST,
    parameter int              OUT_REG      = 1,
    parameter int              CLEAR_ON_RST = 1,
    parameter logic [DATA_W-1:0] CLEAR_VAL  = '0
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_en,
    input  logic                              i_we,
    input  logic [calc_nb(DATA_W,BYTE_W)-1:0] i_be,
    input  logic [ADDR_W-1:0]                 i_addr,
    input  logic [DATA_W-1:0]                 i_din,
    output logic [DATA_W-1:0]                 o_dout,
    output logic                              o_dout_valid,
    output logic                              o_busy
);

    localparam int NB = calc_nb(DATA_W, BYTE_W);
    localparam bram_state_t RST_STATE = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    if (!params_ok(DATA_W, BYTE_W, ADDR_W, DEPTH)) begin : g_bad_params
        $error("sp_bram_bytewr: DATA_W/BYTE_W/ADDR_W/DEPTH inconsistent");
    end

    bram_state_t       r_state;
    bram_state_t       w_state_nxt;
    logic [ADDR_W-1:0] r_clr_addr;
    logic              w_oor;
    logic              w_busy;
    logic              w_we;
    logic              w_rd;
    logic [NB-1:0]     w_be;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_din;
    logic [DATA_W-1:0] w_rdata;
    logic              r_v1;

    if (DEPTH < (1 << ADDR_W)) begin : g_range
        localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
        assign w_oor = (i_addr >= DEPTH_A);
    end else begin : g_full
        assign w_oor = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= RST_STATE;
            r_clr_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_CLEAR) begin
                r_clr_addr <= r_clr_addr + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_CLEAR: if (r_clr_addr == LAST_ADDR) w_state_nxt = ST_RUN;
            ST_RUN:   w_state_nxt = ST_RUN;
        endcase
    end

    // Port mux: the sweep owns the array in CLEAR, the user in RUN.
    always_comb begin
        w_busy = 1'b0;
        w_we   = 1'b0;
        w_rd   = 1'b0;
        w_be   = '0;
        w_addr = i_addr;
        w_din  = i_din;
        unique case (r_state)
            ST_CLEAR: begin
                w_busy = 1'b1;
                w_be   = i_rst ? '0 : '1;
                w_addr = r_clr_addr;
                w_din  = CLEAR_VAL;
            end
            ST_RUN: begin
                w_we = i_en && i_we;
                w_be = (i_en && i_we && !w_oor && !i_rst) ? i_be : '0;
                // No-change mode skips the read register on writes.
                w_rd = i_en && !i_rst &&
                       !(READ_MODE == NO_CHANGE && i_we);
            end
        endcase
    end

    bram_core #(
        .DATA_W    (DATA_W),
        .BYTE_W    (BYTE_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .READ_MODE (READ_MODE)
    ) u_core (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_be    (w_be),
        .i_we    (w_we),
        .i_rd    (w_rd),
        .i_oor   (w_oor),
        .i_addr  (w_addr),
        .i_din   (w_din),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= w_rd;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_W-1:0] r_dout;
        logic              r_v2;
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_dout <= '0;
                r_v2   <= 1'b0;
            end else begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_dout <= w_rdata;
                end
            end
        end
        assign o_dout       = r_dout;
        assign o_dout_valid = r_v2;
    end else begin : g_noreg
        assign o_dout       = w_rdata;
        assign o_dout_valid = r_v1;
    end

    assign o_busy = w_busy;

endmodule

// File: tb/tb_sp_bram_bytewr.sv
// Directed bench for sp_bram_bytewr across four parameter sets.
// k0: 2048x16 read-first OUT_REG=1; k1: write-first OUT_REG=0; k2: no-change; k3: DEPTH=1000.
module tb_sp_bram_bytewr;

    typedef struct {
        int          k;
        logic        we;
        logic [1:0]  be;
        logic [10:0] addr;
        logic [15:0] din;
        logic        chk;
        logic [15:0] exp_d;
        logic        exp_v;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_s   [4];
    logic        we_s   [4];
    logic [1:0]  be_s   [4];
    logic [10:0] addr_s [4];
    logic [15:0] din_s  [4];
    logic [15:0] dout_s [4];
    logic        dv_s   [4];
    logic        busy_s [4];

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vt [31];

    always #5 clk = ~clk;

    sp_bram_bytewr #(.DATA_W(16), .BYTE_W(8), .ADDR_W(11), .DEPTH(2048),
        .READ_MODE(0), .OUT_REG(1), .CLEAR_ON_RST(1), .CLEAR_VAL(16'hA5A5)) u_k0 (
        .i_clk(clk), .i_rst(rst), .i_en(en_s[0]), .i_we(we_s[0]), .i_be(be_s[0]),
        .i_addr(addr_s[0]), .i_din(din_s[0]), .o_dout(dout_s[0]),
        .o_dout_valid(dv_s[0]), .o_busy(busy_s[0]));

    sp_bram_bytewr #(.DATA_W(16), .BYTE_W(8), .ADDR_W(4), .DEPTH(16),
        .READ_MODE(1), .OUT_REG(0), .CLEAR_ON_RST(1), .CLEAR_VAL(16'h0000)) u_k1 (
        .i_clk(clk), .i_rst(rst), .i_en(en_s[1]), .i_we(we_s[1]), .i_be(be_s[1]),
        .i_addr(addr_s[1][3:0]), .i_din(din_s[1]), .o_dout(dout_s[1]),
        .o_dout_valid(dv_s[1]), .o_busy(busy_s[1]));

    sp_bram_bytewr #(.DATA_W(16), .BYTE_W(8), .ADDR_W(4), .DEPTH(16),
        .READ_MODE(2), .OUT_REG(1), .CLEAR_ON_RST(1), .CLEAR_VAL(16'h5A5A)) u_k2 (
        .i_clk(clk), .i_rst(rst), .i_en(en_s[2]), .i_we(we_s[2]), .i_be(be_s[2]),
        .i_addr(addr_s[2][3:0]), .i_din(din_s[2]), .o_dout(dout_s[2]),
        .o_dout_valid(dv_s[2]), .o_busy(busy_s[2]));

    sp_bram_bytewr #(.DATA_W(16), .BYTE_W(8), .ADDR_W(10), .DEPTH(1000),
        .READ_MODE(0), .OUT_REG(1), .CLEAR_ON_RST(0), .CLEAR_VAL(16'h0000)) u_k3 (
        .i_clk(clk), .i_rst(rst), .i_en(en_s[3]), .i_we(we_s[3]), .i_be(be_s[3]),
        .i_addr(addr_s[3][9:0]), .i_din(din_s[3]), .o_dout(dout_s[3]),
        .o_dout_valid(dv_s[3]), .o_busy(busy_s[3]));

    function automatic int lat(input int k);
        return (k == 1) ? 1 : 2;
    endfunction

    task automatic check_v(input string nm, input logic [15:0] got_d,
                           input logic got_v, input logic [15:0] exp_d,
                           input logic exp_v, input logic chk_d);
        n_vec++;
        if ((got_v !== exp_v) || (chk_d && (got_d !== exp_d))) begin
            n_bad++;
            $display("FAIL %s: dout=%h valid=%b, expected dout=%h valid=%b",
                     nm, got_d, got_v, exp_d, exp_v);
        end
    endtask

    task automatic check_i(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        @(negedge clk);
        en_s[v.k]   = 1'b1;
        we_s[v.k]   = v.we;
        be_s[v.k]   = v.be;
        addr_s[v.k] = v.addr;
        din_s[v.k]  = v.din;
        @(negedge clk);
        en_s[v.k] = 1'b0;
        we_s[v.k] = 1'b0;
        be_s[v.k] = 2'b00;
        if (lat(v.k) == 2) @(negedge clk);
        check_v(nm, dout_s[v.k], dv_s[v.k], v.exp_d, v.exp_v, v.chk);
    endtask

    initial begin
        int   cnt [4];
        bit   any;
        int   dv_seen;
        vec_t rv;

        for (int k = 0; k < 4; k++) begin
            en_s[k] = 1'b0; we_s[k] = 1'b0; be_s[k] = 2'b00;
            addr_s[k] = '0; din_s[k] = '0;
        end

        // k, we, be, addr, din, chk, exp_d, exp_v
        vt[0]  = '{0, 1'b0, 2'b00, 11'd0,    16'h0000, 1'b1, 16'hA5A5, 1'b1};
        vt[1]  = '{0, 1'b0, 2'b00, 11'd1023, 16'h0000, 1'b1, 16'hA5A5, 1'b1};
        vt[2]  = '{0, 1'b0, 2'b00, 11'd2047, 16'h0000, 1'b1, 16'hA5A5, 1'b1};
        vt[3]  = '{0, 1'b1, 2'b11, 11'd5,    16'h1234, 1'b1, 16'hA5A5, 1'b1};
        vt[4]  = '{0, 1'b1, 2'b01, 11'd5,    16'hFFEE, 1'b1, 16'h1234, 1'b1};
        vt[5]  = '{0, 1'b0, 2'b00, 11'd5,    16'h0000, 1'b1, 16'h12EE, 1'b1};
        vt[6]  = '{0, 1'b1, 2'b11, 11'd7,    16'h0001, 1'b1, 16'hA5A5, 1'b1};
        vt[7]  = '{0, 1'b1, 2'b11, 11'd7,    16'h0002, 1'b1, 16'h0001, 1'b1};
        vt[8]  = '{0, 1'b0, 2'b00, 11'd7,    16'h0000, 1'b1, 16'h0002, 1'b1};
        vt[9]  = '{0, 1'b1, 2'b00, 11'd9,    16'h0000, 1'b1, 16'hA5A5, 1'b1};
        vt[10] = '{0, 1'b0, 2'b00, 11'd9,    16'h0000, 1'b1, 16'hA5A5, 1'b1};
        vt[11] = '{0, 1'b1, 2'b10, 11'd9,    16'h3C00, 1'b1, 16'hA5A5, 1'b1};
        vt[12] = '{0, 1'b0, 2'b00, 11'd9,    16'h0000, 1'b1, 16'h3CA5, 1'b1};
        vt[13] = '{1, 1'b0, 2'b00, 11'd4,    16'h0000, 1'b1, 16'h0000, 1'b1};
        vt[14] = '{1, 1'b1, 2'b11, 11'd7,    16'h0001, 1'b1, 16'h0001, 1'b1};
        vt[15] = '{1, 1'b1, 2'b11, 11'd7,    16'h0002, 1'b1, 16'h0002, 1'b1};
        vt[16] = '{1, 1'b0, 2'b00, 11'd7,    16'h0000, 1'b1, 16'h0002, 1'b1};
        vt[17] = '{1, 1'b1, 2'b10, 11'd7,    16'hAB00, 1'b1, 16'hAB02, 1'b1};
        vt[18] = '{1, 1'b1, 2'b00, 11'd7,    16'hFFFF, 1'b1, 16'hAB02, 1'b1};
        vt[19] = '{2, 1'b0, 2'b00, 11'd7,    16'h0000, 1'b1, 16'h5A5A, 1'b1};
        vt[20] = '{2, 1'b1, 2'b11, 11'd7,    16'h0001, 1'b1, 16'h5A5A, 1'b0};
        vt[21] = '{2, 1'b1, 2'b11, 11'd7,    16'h0002, 1'b1, 16'h5A5A, 1'b0};
        vt[22] = '{2, 1'b0, 2'b00, 11'd7,    16'h0000, 1'b1, 16'h0002, 1'b1};
        vt[23] = '{2, 1'b1, 2'b01, 11'd7,    16'hFFFF, 1'b1, 16'h0002, 1'b0};
        vt[24] = '{2, 1'b0, 2'b00, 11'd7,    16'h0000, 1'b1, 16'h00FF, 1'b1};
        vt[25] = '{3, 1'b1, 2'b11, 11'd999,  16'h1357, 1'b0, 16'h0000, 1'b1};
        vt[26] = '{3, 1'b0, 2'b00, 11'd999,  16'h0000, 1'b1, 16'h1357, 1'b1};
        vt[27] = '{3, 1'b1, 2'b11, 11'd1010, 16'hFFFF, 1'b1, 16'h0000, 1'b1};
        vt[28] = '{3, 1'b0, 2'b00, 11'd1010, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vt[29] = '{3, 1'b0, 2'b00, 11'd999,  16'h0000, 1'b1, 16'h1357, 1'b1};
        vt[30] = '{3, 1'b0, 2'b00, 11'd1023, 16'h0000, 1'b1, 16'h0000, 1'b1};

        // Single-cycle reset pulse, then reset values and sweep lengths.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_v($sformatf("rst_out_k%0d", k), dout_s[k], dv_s[k],
                    16'h0000, 1'b0, 1'b1);
            check_i($sformatf("rst_busy_k%0d", k), int'(busy_s[k]),
                    (k < 3) ? 1 : 0);
            cnt[k] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            any = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (busy_s[k] === 1'b1) begin
                    cnt[k]++;
                    any = 1'b1;
                end
            end
            if (!any) break;
            @(negedge clk);
        end
        check_i("busy_len_k0", cnt[0], 2048);
        check_i("busy_len_k1", cnt[1], 16);
        check_i("busy_len_k2", cnt[2], 16);
        check_i("busy_len_k3", cnt[3], 0);

        for (int i = 0; i < 31; i++) begin
            run_vec(vt[i], $sformatf("vec%0d", i));
        end

        // Back-to-back reads through the two-stage pipe.
        for (int a = 0; a < 4; a++) begin
            @(negedge clk);
            en_s[0] = 1'b1; we_s[0] = 1'b1; be_s[0] = 2'b11;
            addr_s[0] = 11'(a); din_s[0] = 16'(10 + a);
        end
        @(negedge clk);
        en_s[0] = 1'b0; we_s[0] = 1'b0; be_s[0] = 2'b00;
        repeat (3) @(negedge clk);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check_v("pipe_c1", dout_s[0], dv_s[0], 16'hA5A5, 1'b0, 1'b1);
            end else if (c >= 2 && c <= 5) begin
                check_v($sformatf("pipe_c%0d", c), dout_s[0], dv_s[0],
                        16'(10 + c - 2), 1'b1, 1'b1);
            end else if (c >= 6) begin
                check_v($sformatf("pipe_c%0d", c), dout_s[0], dv_s[0],
                        16'd13, 1'b0, 1'b1);
            end
            en_s[0]   = (c < 4);
            we_s[0]   = 1'b0;
            addr_s[0] = 11'(c);
        end

        // Reset clears dout, then a second reset lands mid-sweep.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check_v("rst_mid_dout", dout_s[0], dv_s[0], 16'h0000, 1'b0, 1'b1);
        repeat (499) @(negedge clk);
        rst = 1'b1;
        en_s[0] = 1'b1; we_s[0] = 1'b1; be_s[0] = 2'b11;
        addr_s[0] = 11'd3; din_s[0] = 16'hBEEF;
        @(negedge clk); rst = 1'b0;
        cnt[0]  = 0;
        dv_seen = 0;
        for (int c = 0; c < 3000; c++) begin
            if (busy_s[0] !== 1'b1) break;
            cnt[0]++;
            if (dv_s[0] === 1'b1) dv_seen++;
            @(negedge clk);
        end
        en_s[0] = 1'b0; we_s[0] = 1'b0; be_s[0] = 2'b00;
        check_i("resweep_len", cnt[0], 2048);
        check_i("resweep_valids", dv_seen, 0);
        rv = '{0, 1'b0, 2'b00, 11'd3, 16'h0000, 1'b1, 16'hA5A5, 1'b1};
        run_vec(rv, "resweep_addr3");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sp_bram_bytewr.md
Name: sp_bram_bytewr

Overview:
- Parametrised successor to the team's fixed 16x2048 single-port block RAM.
- Adds configurable width and depth, per-byte write enables, selectable read-during-write mode and an optional output register.
- Adds a post-reset clear sequencer, so contents are defined and not left as power-up garbage.
- Serves as the general on-chip storage primitive for buffers and lookup tables across the design.

Parameters:
DATA_W, 16, word width in bits; must be a multiple of BYTE_W
BYTE_W, 8, bits per write-enable lane; NB = DATA_W/BYTE_W lanes
ADDR_W, 11, address width
DEPTH, 2048, number of words; must be <= 2**ADDR_W
READ_MODE, 0, read-during-write behaviour: 0 = read-first, 1 = write-first, 2 = no-change
OUT_REG, 1, 1 adds a second output pipeline register
CLEAR_ON_RST, 1, 1 sweeps CLEAR_VAL into every word after reset
CLEAR_VAL, 0, DATA_W-bit value written during the clear sweep

Ports:
clk  in  1  single clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
en  in  1  access request this cycle
we  in  1  write when en=1; read when en=1 and we=0
be  in  NB  byte-lane write enables; be[i] covers din[i*BYTE_W +: BYTE_W]
addr  in  ADDR_W  word address
din  in  DATA_W  write data
dout  out  DATA_W  read data
dout_valid  out  1  one-cycle pulse marking new data on dout
busy  out  1  clear sweep in progress; requests are ignored while high

Behaviour:
- Reset values:
  - dout=0, dout_valid=0, pipeline valid bits=0.
  - busy=1 if CLEAR_ON_RST=1, else 0.
  - The memory array itself is not reset.
- FSM states: CLEAR and RUN.
  - rst forces CLEAR with clr_addr=0 when CLEAR_ON_RST=1; otherwise rst forces RUN.
- CLEAR state:
  - Each cycle with rst low, writes CLEAR_VAL to mem[clr_addr] (all lanes), then increments clr_addr.
  - After writing DEPTH-1, moves to RUN; busy falls in the same edge.
  - The sweep takes exactly DEPTH cycles after rst deasserts.
  - en/we/be are ignored in CLEAR; no dout_valid is produced.
  - rst asserted mid-sweep restarts the sweep at address 0.
- RUN write (en=1, we=1):
  - For each i with be[i]=1, lane i of mem[addr] takes din lane i; other lanes keep their value.
  - be=0 modifies nothing.
- Read port output, per READ_MODE:
  - 0: an array read every en cycle returns the old word.
  - 1: a write cycle returns the merged new word; a read cycle returns the stored word.
  - 2: a write cycle leaves the read register unchanged and produces no dout_valid.
- Latency from the en edge to dout/dout_valid:
  - 1 cycle when OUT_REG=0, 2 cycles when OUT_REG=1.
  - Fully pipelined: one access per cycle, back-to-back allowed.
- dout holds its last value between valid pulses.
- en=0: no array access; the read register and dout hold.
- Out-of-range address (addr >= DEPTH, only possible when DEPTH < 2**ADDR_W):
  - Writes are dropped.
  - Reads return 0 with dout_valid asserted.
- Reset mid-operation: in-flight pipeline valids are cleared, and dout returns to 0 the cycle after rst.
- Array coding must remain block-RAM inferable:
  - No reset on the array.
  - Registered read.
  - Byte-lane write loop.

Decomposition:
- Shared package bram_pkg holds:
  - RD_FIRST=0, WR_FIRST=1, NO_CHANGE=2.
  - The function computing NB.
  - An assertion helper checking DATA_W % BYTE_W == 0 and DEPTH <= 2**ADDR_W.
- Sub-module bram_core holds:
  - The array.
  - The byte-lane write.
  - The READ_MODE read register.
- The top level (sp_bram_bytewr) holds:
  - The clear FSM and clr_addr counter.
  - The port mux (clear vs user).
  - The range check.
  - The OUT_REG stage and valid pipeline.

Test Plan:
- Clear: DEPTH=2048, CLEAR_VAL=16'hA5A5, pulse rst for 1 cycle -> busy high for exactly 2048 cycles; then reads of addr 0, 1023, 2047 give 16'hA5A5 with latency 2.
- Byte enable: write 16'h1234 to addr 5 with be=2'b11, then write 16'hFFEE with be=2'b01 -> read of addr 5 returns 16'h12EE.
- Read-during-write: mem[7]=16'h0001, write 16'h0002 to addr 7 with be=2'b11:
  - READ_MODE=0: dout=16'h0001.
  - READ_MODE=1: dout=16'h0002.
  - READ_MODE=2: no dout_valid, dout unchanged.
  - In every mode, a later read of addr 7 returns 16'h0002.
- Pipelining: OUT_REG=1, reads on 4 consecutive cycles of addr 0..3 preloaded with 10,11,12,13 -> dout_valid high 4 consecutive cycles starting 2 cycles after the first request, with data 10,11,12,13.
- Reset mid-sweep: assert rst at clear cycle 500 -> sweep restarts at 0; busy lasts 2048 further cycles; requests issued while busy are ignored (no valid pulse, no write).
- Out-of-range: DEPTH=1000, ADDR_W=10, write addr 1010 then read addr 1010 -> dout=0, dout_valid=1; addr 999 contents unaffected.
